uart_rx_fifo_ctrl: RTL and testbench

//  Receive-side buffer controller for the 16550 core. Sits between the bit-level RX deserialiser and
//  the register file: stores each received character plus its PE/FE/BI flags in a FIFO, and maintains
//  the LSR receive bits (DR, OE, PE, FE, BI, RXFE). Generates the received-data-available (trigger-level)
//  and character-timeout interrupt requests.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_sync_fifo.sv | 59 +++++
 rtl/uart_rx_fifo_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_uart_rx_fifo_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART receive path
// Purpose: receive FIFO entry layout, character-timeout FSM states, and
//          helpers that decode the trigger level and the character length.
// Ports:   none (package)
package uart_pkg;

   typedef struct packed {
      logic       bi;
      logic       fe;
      logic       pe;
      logic [7:0] data;
   } rx_entry_t;

   typedef enum logic [1:0] {
      T_IDLE,
      T_COUNT,
      T_FIRED
   } to_state_t;

   // FCR[7:6] trigger encoding: 1, 4, 8 or 14 entries.
   function automatic logic [4:0] trig_count(input logic [1:0] trig_lvl);
      case (trig_lvl)
         2'b00:   return 5'd1;
         2'b01:   return 5'd4;
         2'b10:   return 5'd8;
         default: return 5'd14;
      endcase
   endfunction

   // Bits per character on the line: start + data + parity + stop.
   // 1.5 stop bits are counted as 2, so the fixed part is start + 1 stop + 5 data.
   function automatic logic [3:0] char_bits(input logic [1:0] wls, input logic pen, input logic stb);
      return 4'd7 + 4'(wls) + 4'(pen) + 4'(stb);
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO storage with level count
// Purpose: circular buffer with power-of-2 depth; the caller qualifies wr/rd
//          (no internal full/empty protection), so a simultaneous rd+wr on a
//          full FIFO is legal and leaves the level unchanged.
// Ports:   clk, rst (sync, active-high), flush (clears pointers/level),
//          wr/din (write strobe and data), rd (pop strobe),
//          dout (head entry), level (entry count, 0..DEPTH)
module uart_sync_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     wr,
   input  logic [WIDTH-1:0]         din,
   input  logic                     rd,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   // Storage needs no reset: the head is only observed while level != 0.
   always_ff @(posedge clk) begin
      if (wr) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of 2.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr, rd})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// rtl/uart_rx_fifo_ctrl.sv - 16550 receive buffer, LSR receive bits and RX interrupts
// Purpose: buffers received characters with their PE/FE/BI flags, drives
//          LSR DR/OE/PE/FE/BI/RXFE, the trigger-level interrupt and the
//          character-timeout interrupt.
// Ports:   clk, rst (sync, active-high), baud_pulse (16x tick),
//          push/din/pe_in/fe_in/bi_in (character from deserialiser),
//          rbr_rd/lsr_rd (host read strobes), fifo_en/rx_fifo_rst/trig_lvl (FCR),
//          wls/pen/stb (LCR line format),
//          dout/dr/oe/pe/fe/bi/rxfe (RBR and LSR), rda_irq, cti_irq, level
module uart_rx_fifo_ctrl
   import uart_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int TO_CHARS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    baud_pulse,
   input  logic                    push,
   input  logic [7:0]              din,
   input  logic                    pe_in,
   input  logic                    fe_in,
   input  logic                    bi_in,
   input  logic                    rbr_rd,
   input  logic                    lsr_rd,
   input  logic                    fifo_en,
   input  logic                    rx_fifo_rst,
   input  logic [1:0]              trig_lvl,
   input  logic [1:0]              wls,
   input  logic                    pen,
   input  logic                    stb,
   output logic [7:0]              dout,
   output logic                    dr,
   output logic                    oe,
   output logic                    pe,
   output logic                    fe,
   output logic                    bi,
   output logic                    rxfe,
   output logic                    rda_irq,
   output logic                    cti_irq,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int LW = $clog2(DEPTH) + 1;

   rx_entry_t        head;
   rx_entry_t        wentry;
   logic [10:0]      rdata;
   logic             fifo_en_q;
   logic             flush;
   logic             empty;
   logic             full;
   logic             pop;
   logic             wr;
   logic             overrun;
   logic [LW-1:0]    cap;
   logic [LW-1:0]    err_cnt;
   logic             new_err;
   logic             head_err;
   logic             oe_q;
   logic             rda_q;
   to_state_t        state_q;
   to_state_t        state_d;
   logic [9:0]       tcnt_q;
   logic [9:0]       tcnt_d;
   logic [15:0]      to_lim;
   logic             at_lim;
   logic             activity;

   // Tracks fifo_en even through reset so leaving reset never looks like a mode change.
   always_ff @(posedge clk) begin
      fifo_en_q <= fifo_en;
   end

   assign flush    = rx_fifo_rst | (fifo_en != fifo_en_q);
   assign cap      = fifo_en ? LW'(DEPTH) : LW'(1);
   assign empty    = (level == '0);
   assign full     = (level >= cap);
   // A read frees a slot before the write lands, so a full FIFO accepts push+read.
   assign pop      = rbr_rd & ~empty & ~flush;
   assign wr       = push & ~flush & (~full | pop);
   assign overrun  = push & ~flush & full & ~pop;
   assign wentry   = '{bi: bi_in, fe: fe_in, pe: pe_in, data: din};
   assign head     = rx_entry_t'(rdata);
   assign new_err  = bi_in | fe_in | pe_in;
   assign head_err = head.bi | head.fe | head.pe;

   uart_sync_fifo #(
      .WIDTH ($bits(rx_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .wr    (wr),
      .din   (wentry),
      .rd    (pop),
      .dout  (rdata),
      .level (level)
   );

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         err_cnt <= '0;
      end else begin
         case ({wr & new_err, pop & head_err})
            2'b10:   err_cnt <= err_cnt + LW'(1);
            2'b01:   err_cnt <= err_cnt - LW'(1);
            default: err_cnt <= err_cnt;
         endcase
      end
   end

   // Overrun survives a flush; a coincident LSR read loses to a new overrun.
   always_ff @(posedge clk) begin
      if (rst) begin
         oe_q <= 1'b0;
      end else if (overrun) begin
         oe_q <= 1'b1;
      end else if (lsr_rd) begin
         oe_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rda_q <= 1'b0;
      end else if (fifo_en) begin
         rda_q <= (int'(level) >= int'(trig_count(trig_lvl)));
      end else begin
         rda_q <= ~empty;
      end
   end

   assign to_lim   = 16'(TO_CHARS * 16) * {12'd0, char_bits(wls, pen, stb)};
   assign at_lim   = ({6'd0, tcnt_q} == (to_lim - 16'd1));
   assign activity = push | rbr_rd;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state_q <= T_IDLE;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q;
      if (!fifo_en) begin
         state_d = T_IDLE;
         tcnt_d  = '0;
      end else begin
         case (state_q)
            T_IDLE: begin
               tcnt_d = '0;
               if (!empty) begin
                  state_d = T_COUNT;
               end
            end
            T_COUNT: begin
               if (empty) begin
                  state_d = T_IDLE;
                  tcnt_d  = '0;
               end else if (activity) begin
                  tcnt_d = '0;
               end else if (baud_pulse) begin
                  if (at_lim) begin
                     state_d = T_FIRED;
                     tcnt_d  = '0;
                  end else begin
                     tcnt_d = tcnt_q + 10'd1;
                  end
               end
            end
            T_FIRED: begin
               if (empty) begin
                  state_d = T_IDLE;
                  tcnt_d  = '0;
               end else if (activity) begin
                  state_d = T_COUNT;
                  tcnt_d  = '0;
               end
            end
            default: begin
               state_d = T_IDLE;
               tcnt_d  = '0;
            end
         endcase
      end
   end

   assign dout    = empty ? 8'h00 : head.data;
   assign pe      = ~empty & head.pe;
   assign fe      = ~empty & head.fe;
   assign bi      = ~empty & head.bi;
   assign dr      = ~empty;
   assign oe      = oe_q;
   assign rxfe    = (err_cnt != '0);
   assign rda_irq = rda_q;
   assign cti_irq = (state_q == T_FIRED);

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// tb/tb_uart_rx_fifo_ctrl.sv - self-checking bench for uart_rx_fifo_ctrl
module tb_uart_rx_fifo_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        baud_pulse;
   logic        push;
   logic [7:0]  din;
   logic        pe_in, fe_in, bi_in;
   logic        rbr_rd, lsr_rd;
   logic        fifo_en, rx_fifo_rst;
   logic [1:0]  trig_lvl, wls;
   logic        pen, stb;
   logic [7:0]  dout;
   logic        dr, oe, pe, fe, bi, rxfe, rda_irq, cti_irq;
   logic [4:0]  level;

   int          checks = 0;
   int          errors = 0;
   logic [10:0] sb [$];

   always #5 clk = ~clk;

   uart_rx_fifo_ctrl #(.DEPTH(16), .TO_CHARS(4)) dut (
      .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .push(push), .din(din),
      .pe_in(pe_in), .fe_in(fe_in), .bi_in(bi_in), .rbr_rd(rbr_rd), .lsr_rd(lsr_rd),
      .fifo_en(fifo_en), .rx_fifo_rst(rx_fifo_rst), .trig_lvl(trig_lvl), .wls(wls),
      .pen(pen), .stb(stb), .dout(dout), .dr(dr), .oe(oe), .pe(pe), .fe(fe), .bi(bi),
      .rxfe(rxfe), .rda_irq(rda_irq), .cti_irq(cti_irq), .level(level)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; baud_pulse = 1'b0; push = 1'b0; din = 8'h00;
      pe_in = 1'b0; fe_in = 1'b0; bi_in = 1'b0; rbr_rd = 1'b0; lsr_rd = 1'b0;
      fifo_en = 1'b1; rx_fifo_rst = 1'b0; trig_lvl = 2'b00;
      wls = 2'b11; pen = 1'b0; stb = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      sb.delete();
   endtask

   task automatic push_char(input logic [7:0] d, input logic p, input logic f, input logic b);
      int cap;
      cap = fifo_en ? 16 : 1;
      push = 1'b1; din = d; pe_in = p; fe_in = f; bi_in = b;
      if (sb.size() < cap) sb.push_back({b, f, p, d});
      tick();
      push = 1'b0; pe_in = 1'b0; fe_in = 1'b0; bi_in = 1'b0;
   endtask

   task automatic pop_check();
      logic [10:0] exp;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL pop_underflow: scoreboard empty, dut dr=%0b dout=%0h", dr, dout);
      end else begin
         exp = sb.pop_front();
         if ({bi, fe, pe, dout} !== exp) begin
            errors++;
            $display("FAIL pop_data: got %03h expected %03h", {bi, fe, pe, dout}, exp);
         end
      end
      rbr_rd = 1'b1;
      tick();
      rbr_rd = 1'b0;
   endtask

   task automatic push_pop(input logic [7:0] d);
      logic [10:0] exp;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL push_pop_underflow: scoreboard empty");
      end else begin
         exp = sb.pop_front();
         if ({bi, fe, pe, dout} !== exp) begin
            errors++;
            $display("FAIL push_pop_head: got %03h expected %03h", {bi, fe, pe, dout}, exp);
         end
      end
      sb.push_back({3'b000, d});
      push = 1'b1; din = d; rbr_rd = 1'b1;
      tick();
      push = 1'b0; rbr_rd = 1'b0;
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         baud_pulse = 1'b1;
         tick();
         baud_pulse = 1'b0;
         tick();
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
      checks++; if (dr !== 1'b0) begin errors++; $display("FAIL reset_dr: got %0b expected 0", dr); end
      checks++; if (oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %0b expected 0", oe); end
      checks++; if (rxfe !== 1'b0) begin errors++; $display("FAIL reset_rxfe: got %0b expected 0", rxfe); end
      checks++; if (rda_irq !== 1'b0) begin errors++; $display("FAIL reset_rda: got %0b expected 0", rda_irq); end
      checks++; if (cti_irq !== 1'b0) begin errors++; $display("FAIL reset_cti: got %0b expected 0", cti_irq); end
      checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %0h expected 0", dout); end
      checks++; if ({pe, fe, bi} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %03b expected 000", {pe, fe, bi}); end
   endtask

   task automatic test_trigger();
      do_reset();
      trig_lvl = 2'b01;
      tick();
      push_char(8'h41, 1'b0, 1'b0, 1'b0);
      push_char(8'h42, 1'b0, 1'b0, 1'b0);
      push_char(8'h43, 1'b0, 1'b0, 1'b0);
      tick();
      checks++; if (rda_irq !== 1'b0) begin errors++; $display("FAIL trig_below: got %0b expected 0", rda_irq); end
      checks++; if (level !== 5'd3) begin errors++; $display("FAIL trig_level3: got %0d expected 3", level); end
      push_char(8'h44, 1'b0, 1'b0, 1'b0);
      tick();
      checks++; if (rda_irq !== 1'b1) begin errors++; $display("FAIL trig_reached: got %0b expected 1", rda_irq); end
      checks++; if (level !== 5'd4) begin errors++; $display("FAIL trig_level4: got %0d expected 4", level); end
      trig_lvl = 2'b11;
      tick();
      checks++; if (rda_irq !== 1'b0) begin errors++; $display("FAIL trig_change14: got %0b expected 0", rda_irq); end
      trig_lvl = 2'b01;
      tick();
      for (int i = 0; i < 4; i++) pop_check();
      checks++; if (dr !== 1'b0) begin errors++; $display("FAIL trig_drained_dr: got %0b expected 0", dr); end
   endtask

   task automatic test_overrun();
      do_reset();
      for (int i = 0; i < 17; i++) push_char(8'h60 + 8'(i), 1'b0, 1'b0, 1'b0);
      checks++; if (oe !== 1'b1) begin errors++; $display("FAIL ovr_oe_set: got %0b expected 1", oe); end
      checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovr_level: got %0d expected 16", level); end
      lsr_rd = 1'b1;
      tick();
      lsr_rd = 1'b0;
      checks++; if (oe !== 1'b0) begin errors++; $display("FAIL ovr_lsr_clear: got %0b expected 0", oe); end
      push_pop(8'hA0);
      checks++; if (oe !== 1'b0) begin errors++; $display("FAIL ovr_pushpop_oe: got %0b expected 0", oe); end
      checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovr_pushpop_level: got %0d expected 16", level); end
      for (int i = 0; i < 16; i++) pop_check();
      checks++; if (dr !== 1'b0) begin errors++; $display("FAIL ovr_drained_dr: got %0b expected 0", dr); end
   endtask

   task automatic test_error_flag();
      do_reset();
      push_char(8'h11, 1'b0, 1'b0, 1'b0);
      push_char(8'h55, 1'b0, 1'b1, 1'b0);
      push_char(8'h22, 1'b0, 1'b0, 1'b0);
      checks++; if (rxfe !== 1'b1) begin errors++; $display("FAIL err_rxfe_set: got %0b expected 1", rxfe); end
      checks++; if (fe !== 1'b0) begin errors++; $display("FAIL err_fe_not_head: got %0b expected 0", fe); end
      pop_check();
      checks++; if (fe !== 1'b1) begin errors++; $display("FAIL err_fe_head: got %0b expected 1", fe); end
      pop_check();
      checks++; if (rxfe !== 1'b0) begin errors++; $display("FAIL err_rxfe_clear: got %0b expected 0", rxfe); end
      pop_check();
   endtask

   task automatic test_timeout();
      do_reset();
      push_char(8'h77, 1'b0, 1'b0, 1'b0);
      tick(); tick(); tick();
      pulses(639);
      checks++; if (cti_irq !== 1'b0) begin errors++; $display("FAIL cti_early_640: got %0b expected 0", cti_irq); end
      pulses(1);
      checks++; if (cti_irq !== 1'b1) begin errors++; $display("FAIL cti_fire_640: got %0b expected 1", cti_irq); end
      pop_check();
      checks++; if (cti_irq !== 1'b0) begin errors++; $display("FAIL cti_read_clear: got %0b expected 0", cti_irq); end
   endtask

   task automatic test_rst_mid();
      do_reset();
      wls = 2'b00; pen = 1'b1; stb = 1'b1;
      push_char(8'h33, 1'b0, 1'b0, 1'b0);
      tick(); tick(); tick();
      pulses(575);
      checks++; if (cti_irq !== 1'b0) begin errors++; $display("FAIL cti_early_576: got %0b expected 0", cti_irq); end
      pulses(1);
      checks++; if (cti_irq !== 1'b1) begin errors++; $display("FAIL cti_fire_576: got %0b expected 1", cti_irq); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      checks++; if (cti_irq !== 1'b0) begin errors++; $display("FAIL rst_cti: got %0b expected 0", cti_irq); end
      checks++; if (level !== 5'd0) begin errors++; $display("FAIL rst_level: got %0d expected 0", level); end
   endtask

   task automatic test_16450();
      do_reset();
      fifo_en = 1'b0;
      tick(); tick();
      push_char(8'h10, 1'b0, 1'b0, 1'b0);
      checks++; if (dr !== 1'b1) begin errors++; $display("FAIL m16450_dr: got %0b expected 1", dr); end
      tick();
      checks++; if (rda_irq !== 1'b1) begin errors++; $display("FAIL m16450_rda_set: got %0b expected 1", rda_irq); end
      push_char(8'h20, 1'b0, 1'b0, 1'b0);
      checks++; if (oe !== 1'b1) begin errors++; $display("FAIL m16450_oe: got %0b expected 1", oe); end
      checks++; if (dout !== 8'h10) begin errors++; $display("FAIL m16450_dout: got %0h expected 10", dout); end
      pop_check();
      checks++; if (dr !== 1'b0) begin errors++; $display("FAIL m16450_dr_clear: got %0b expected 0", dr); end
      tick();
      checks++; if (rda_irq !== 1'b0) begin errors++; $display("FAIL m16450_rda_clear: got %0b expected 0", rda_irq); end
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 17; i++) push_char(8'h80 + 8'(i), (i == 13), 1'b0, 1'b0);
      checks++; if (oe !== 1'b1) begin errors++; $display("FAIL flush_pre_oe: got %0b expected 1", oe); end
      for (int i = 0; i < 11; i++) pop_check();
      checks++; if (level !== 5'd5) begin errors++; $display("FAIL flush_pre_level: got %0d expected 5", level); end
      checks++; if (rxfe !== 1'b1) begin errors++; $display("FAIL flush_pre_rxfe: got %0b expected 1", rxfe); end
      rx_fifo_rst = 1'b1; push = 1'b1; din = 8'h99;
      tick();
      rx_fifo_rst = 1'b0; push = 1'b0;
      sb.delete();
      checks++; if (level !== 5'd0) begin errors++; $display("FAIL flush_level: got %0d expected 0", level); end
      checks++; if (dr !== 1'b0) begin errors++; $display("FAIL flush_dr: got %0b expected 0", dr); end
      checks++; if (oe !== 1'b1) begin errors++; $display("FAIL flush_oe_kept: got %0b expected 1", oe); end
      checks++; if (rxfe !== 1'b0) begin errors++; $display("FAIL flush_rxfe: got %0b expected 0", rxfe); end
      push_char(8'h5A, 1'b0, 1'b0, 1'b0);
      checks++; if (level !== 5'd1) begin errors++; $display("FAIL flush_after_level: got %0d expected 1", level); end
      pop_check();
   endtask

   initial begin
      test_reset();
      test_trigger();
      test_overrun();
      test_error_flag();
      test_timeout();
      test_rst_mid();
      test_16450();
      test_flush();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
